// File: rtl/safety_island_obi_sram_sbr.sv
// OBI subordinate terminating a manager port onto a single-port SRAM with 1-cycle read latency.
// Responses flow through a fall-through FIFO; grant is throttled so no response is ever lost.
module safety_island_obi_sram_sbr #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned RspDepth  = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [AddrWidth-1:0]        addr_i,
  input  logic                        we_i,
  input  logic [DataWidth/8-1:0]      be_i,
  input  logic [DataWidth-1:0]        wdata_i,
  input  logic [IdWidth-1:0]          aid_i,
  output logic                        rvalid_o,
  input  logic                        rready_i,
  output logic [DataWidth-1:0]        rdata_o,
  output logic [IdWidth-1:0]          rid_o,
  output logic                        err_o,
  output logic                        sram_req_o,
  output logic                        sram_we_o,
  output logic [$clog2(NumWords)-1:0] sram_addr_o,
  output logic [DataWidth-1:0]        sram_wdata_o,
  output logic [DataWidth/8-1:0]      sram_be_o,
  input  logic [DataWidth-1:0]        sram_rdata_i
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned OffWidth = $clog2(BeWidth);
  localparam int unsigned SramAw   = $clog2(NumWords);
  localparam int unsigned CntWidth = $clog2(RspDepth + 1);
  localparam int unsigned PtrWidth = $clog2(RspDepth);
  localparam int unsigned EntWidth = IdWidth + 1 + DataWidth;

  logic [AddrWidth-1:0] w_index;
  logic                 w_inRange;
  logic                 w_accept;
  logic                 w_retire;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifoEmpty;
  logic [DataWidth-1:0] w_stageRdata;
  logic [EntWidth-1:0]  w_stageRsp;
  logic [EntWidth-1:0]  w_headRsp;
  logic [EntWidth-1:0]  w_outRsp;

  logic                 r_stageValid;
  logic [IdWidth-1:0]   r_stageId;
  logic                 r_stageWe;
  logic                 r_stageErr;
  logic [CntWidth-1:0]  r_cnt;
  logic [CntWidth-1:0]  r_occ;
  logic [PtrWidth-1:0]  r_wrPtr;
  logic [PtrWidth-1:0]  r_rdPtr;
  logic [EntWidth-1:0]  r_fifoMem [RspDepth];

  function automatic logic [PtrWidth-1:0] ptrInc(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(RspDepth - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  assign w_index   = addr_i >> OffWidth;
  assign w_inRange = ({1'b0, w_index} < (AddrWidth + 1)'(NumWords));

  // A retire in this cycle frees a slot, so grant may reopen in the same cycle.
  assign w_retire = rvalid_o & rready_i;
  assign gnt_o    = (r_cnt < CntWidth'(RspDepth)) | w_retire;
  assign w_accept = req_i & gnt_o;

  assign sram_req_o   = w_accept & w_inRange;
  assign sram_we_o    = we_i;
  assign sram_addr_o  = w_index[SramAw-1:0];
  assign sram_wdata_o = wdata_i;
  assign sram_be_o    = be_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stageValid <= 1'b0;
      r_stageId    <= '0;
      r_stageWe    <= 1'b0;
      r_stageErr   <= 1'b0;
    end else begin
      r_stageValid <= w_accept;
      if (w_accept) begin
        r_stageId  <= aid_i;
        r_stageWe  <= we_i;
        r_stageErr <= ~w_inRange;
      end
    end
  end

  assign w_stageRdata = (r_stageValid && !r_stageWe && !r_stageErr) ? sram_rdata_i : '0;
  assign w_stageRsp   = r_stageValid ? {r_stageId, r_stageErr, w_stageRdata} : '0;

  // Fall-through: an empty FIFO exposes the stage directly and is skipped if it retires at once.
  assign w_fifoEmpty = (r_occ == '0);
  assign w_headRsp   = r_fifoMem[r_rdPtr];
  assign w_outRsp    = w_fifoEmpty ? w_stageRsp : w_headRsp;
  assign rvalid_o    = w_fifoEmpty ? r_stageValid : 1'b1;
  assign w_push      = r_stageValid & ~(w_fifoEmpty & rready_i);
  assign w_pop       = ~w_fifoEmpty & rready_i;

  assign {rid_o, err_o, rdata_o} = w_outRsp;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr] <= w_stageRsp;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_occ   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= ptrInc(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= ptrInc(r_rdPtr);
      end
      r_occ <= r_occ + CntWidth'(w_push) - CntWidth'(w_pop);
      r_cnt <= r_cnt + CntWidth'(w_accept) - CntWidth'(w_retire);
    end
  end

endmodule
